// File: rtl/h264_cavlc_pkg.sv
// Shared CAVLC definitions: block modes, decoder states and total_zeros code tables.
package h264_cavlc_pkg;

  localparam logic [1:0] MODE_LUMA   = 2'd0;
  localparam logic [1:0] MODE_CDC420 = 2'd1;
  localparam logic [1:0] MODE_CDC422 = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;

  // Longest total_zeros codeword, and so the LUT window width.
  localparam int unsigned TZ_MAX_LEN = 9;

  typedef enum logic [1:0] {StIdle, StWait, StDone} tz_state_e;

  // Table entry {len[3:0], code[8:0]} with the code right-aligned; len 0 marks no codeword.
  typedef logic [12:0] tz_cw_t;

  function automatic tz_cw_t cw(input int unsigned len, input int unsigned code);
    return {len[3:0], code[8:0]};
  endfunction

  localparam tz_cw_t NO_CW = '0;

  // 4x4 luma/AC, row = total_coeff-1, column = total_zeros.
  localparam tz_cw_t LUMA_TAB [15][16] = '{
    '{cw(1,1), cw(3,3), cw(3,2), cw(4,3), cw(4,2), cw(5,3), cw(5,2), cw(6,3),
      cw(6,2), cw(7,3), cw(7,2), cw(8,3), cw(8,2), cw(9,3), cw(9,2), cw(9,1)},
    '{cw(3,7), cw(3,6), cw(3,5), cw(3,4), cw(3,3), cw(4,5), cw(4,4), cw(4,3),
      cw(4,2), cw(5,3), cw(5,2), cw(6,3), cw(6,2), cw(6,1), cw(6,0), NO_CW},
    '{cw(4,5), cw(3,7), cw(3,6), cw(3,5), cw(4,4), cw(4,3), cw(3,4), cw(3,3),
      cw(4,2), cw(5,3), cw(5,2), cw(6,1), cw(5,1), cw(6,0), NO_CW, NO_CW},
    '{cw(5,3), cw(3,7), cw(4,5), cw(4,4), cw(3,6), cw(3,5), cw(3,4), cw(4,3),
      cw(3,3), cw(4,2), cw(5,2), cw(5,1), cw(5,0), NO_CW, NO_CW, NO_CW},
    '{cw(4,5), cw(4,4), cw(4,3), cw(3,7), cw(3,6), cw(3,5), cw(3,4), cw(3,3),
      cw(4,2), cw(5,1), cw(4,1), cw(5,0), NO_CW, NO_CW, NO_CW, NO_CW},
    '{cw(6,1), cw(5,1), cw(3,7), cw(3,6), cw(3,5), cw(3,4), cw(3,3), cw(3,2),
      cw(4,1), cw(3,1), cw(6,0), NO_CW, NO_CW, NO_CW, NO_CW, NO_CW},
    '{cw(6,1), cw(5,1), cw(3,5), cw(3,4), cw(3,3), cw(2,3), cw(3,2), cw(4,1),
      cw(3,1), cw(6,0), NO_CW, NO_CW, NO_CW, NO_CW, NO_CW, NO_CW},
    '{cw(6,1), cw(4,1), cw(5,1), cw(3,3), cw(2,3), cw(2,2), cw(3,2), cw(3,1),
      cw(6,0), NO_CW, NO_CW, NO_CW, NO_CW, NO_CW, NO_CW, NO_CW},
    '{cw(6,1), cw(6,0), cw(4,1), cw(2,3), cw(2,2), cw(3,1), cw(2,1), cw(5,1),
      NO_CW, NO_CW, NO_CW, NO_CW, NO_CW, NO_CW, NO_CW, NO_CW},
    '{cw(5,1), cw(5,0), cw(3,1), cw(2,3), cw(2,2), cw(2,1), cw(4,1), NO_CW,
      NO_CW, NO_CW, NO_CW, NO_CW, NO_CW, NO_CW, NO_CW, NO_CW},
    '{cw(4,0), cw(4,1), cw(3,1), cw(3,2), cw(1,1), cw(3,3), NO_CW, NO_CW,
      NO_CW, NO_CW, NO_CW, NO_CW, NO_CW, NO_CW, NO_CW, NO_CW},
    '{cw(4,0), cw(4,1), cw(2,1), cw(1,1), cw(3,1), NO_CW, NO_CW, NO_CW,
      NO_CW, NO_CW, NO_CW, NO_CW, NO_CW, NO_CW, NO_CW, NO_CW},
    '{cw(3,0), cw(3,1), cw(1,1), cw(2,1), NO_CW, NO_CW, NO_CW, NO_CW,
      NO_CW, NO_CW, NO_CW, NO_CW, NO_CW, NO_CW, NO_CW, NO_CW},
    '{cw(2,0), cw(2,1), cw(1,1), NO_CW, NO_CW, NO_CW, NO_CW, NO_CW,
      NO_CW, NO_CW, NO_CW, NO_CW, NO_CW, NO_CW, NO_CW, NO_CW},
    '{cw(1,0), cw(1,1), NO_CW, NO_CW, NO_CW, NO_CW, NO_CW, NO_CW,
      NO_CW, NO_CW, NO_CW, NO_CW, NO_CW, NO_CW, NO_CW, NO_CW}
  };

  // Chroma DC 4:2:0.
  localparam tz_cw_t C420_TAB [3][4] = '{
    '{cw(1,1), cw(2,1), cw(3,1), cw(3,0)},
    '{cw(1,1), cw(2,1), cw(2,0), NO_CW},
    '{cw(1,1), cw(1,0), NO_CW, NO_CW}
  };

  // Chroma DC 4:2:2.
  localparam tz_cw_t C422_TAB [7][8] = '{
    '{cw(1,1), cw(3,2), cw(3,3), cw(4,2), cw(4,3), cw(4,1), cw(5,1), cw(5,0)},
    '{cw(3,0), cw(2,1), cw(3,1), cw(3,4), cw(3,5), cw(3,6), cw(3,7), NO_CW},
    '{cw(3,0), cw(3,1), cw(2,1), cw(2,2), cw(3,6), cw(3,7), NO_CW, NO_CW},
    '{cw(3,6), cw(2,0), cw(2,1), cw(2,2), cw(3,7), NO_CW, NO_CW, NO_CW},
    '{cw(2,0), cw(2,1), cw(2,2), cw(2,3), NO_CW, NO_CW, NO_CW, NO_CW},
    '{cw(2,0), cw(2,1), cw(1,1), NO_CW, NO_CW, NO_CW, NO_CW, NO_CW},
    '{cw(1,0), cw(1,1), NO_CW, NO_CW, NO_CW, NO_CW, NO_CW, NO_CW}
  };

endpackage

// File: rtl/tz_lut.sv
// Combinational total_zeros lookup: leading-one detection plus all three table sets.
module tz_lut
  import h264_cavlc_pkg::*;
(
  input  logic [1:0]            mode,
  input  logic [4:0]            total_coeff,
  input  logic [TZ_MAX_LEN-1:0] win,
  output logic [3:0]            total_zeros,
  output logic [3:0]            tz_len,
  output logic                  match
);

  logic [3:0]            lead_zeros;
  logic [TZ_MAX_LEN-1:0] win_masked;
  logic [3:0]            row_l;
  logic [1:0]            row_c0;
  logic [2:0]            row_c2;
  tz_cw_t                row [16];

  assign row_l  = 4'(total_coeff - 5'd1);
  assign row_c0 = 2'(total_coeff - 5'd1);
  assign row_c2 = 3'(total_coeff - 5'd1);

  // Leading-one detector: zeros ahead of the first 1, 9 when the window is all zero.
  always_comb begin
    lead_zeros = 4'(TZ_MAX_LEN);
    for (int i = 0; i < int'(TZ_MAX_LEN); i++) begin
      if (win[TZ_MAX_LEN-1-i] && lead_zeros == 4'(TZ_MAX_LEN)) lead_zeros = 4'(i);
    end
  end

  // No codeword extends more than two bits past the leading one, so drop the rest.
  always_comb begin
    for (int i = 0; i < int'(TZ_MAX_LEN); i++) begin
      win_masked[i] = win[i] && ((int'(TZ_MAX_LEN) - 1 - i) <= (int'(lead_zeros) + 2));
    end
  end

  // Select the table row; unsupported rows stay empty and therefore never match.
  always_comb begin
    for (int v = 0; v < 16; v++) row[v] = NO_CW;
    case (mode)
      MODE_LUMA: begin
        if (total_coeff >= 5'd1 && total_coeff <= 5'd15) row = LUMA_TAB[row_l];
      end
      MODE_CDC420: begin
        if (total_coeff >= 5'd1 && total_coeff <= 5'd3) begin
          for (int v = 0; v < 4; v++) row[v] = C420_TAB[row_c0][v];
        end
      end
      MODE_CDC422: begin
        if (total_coeff >= 5'd1 && total_coeff <= 5'd7) begin
          for (int v = 0; v < 8; v++) row[v] = C422_TAB[row_c2][v];
        end
      end
      default: ;
    endcase
  end

  // Prefix-free tables: at most one entry matches the head of the window.
  always_comb begin
    total_zeros = '0;
    tz_len      = '0;
    match       = 1'b0;
    for (int v = 0; v < 16; v++) begin
      if (!match && row[v][12:9] != 4'd0 &&
          (win_masked >> (4'(TZ_MAX_LEN) - row[v][12:9])) == row[v][8:0]) begin
        match       = 1'b1;
        total_zeros = 4'(v);
        tz_len      = row[v][12:9];
      end
    end
  end

endmodule

// File: rtl/total_zeros_decoder_mc.sv
// Multi-mode CAVLC total_zeros decoder with start/done handshake and registered results.
module total_zeros_decoder_mc
  import h264_cavlc_pkg::*;
#(
  parameter int unsigned WIN_W  = 16,
  parameter bit          EN_422 = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [4:0]       total_coeff,
  input  logic [1:0]       block_mode,
  input  logic [4:0]       max_num_coeff,
  input  logic [WIN_W-1:0] bits_in,
  input  logic             bits_valid,
  output logic             busy,
  output logic             done,
  output logic [3:0]       total_zeros,
  output logic [3:0]       tz_len,
  output logic             consume,
  output logic [3:0]       zeros_left,
  output logic             run_needed,
  output logic             err
);

  tz_state_e  state_q, state_d;
  logic [4:0] tc_q, tc_d;
  logic [1:0] mode_q, mode_d;
  logic [3:0] tz_q, tz_d;
  logic [3:0] len_q, len_d;
  logic       run_q, run_d;
  logic       err_q, err_d;

  logic       req_err, req_skip, req_no_row;
  logic [3:0] lut_tz, lut_len;
  logic       lut_match;

  // Only the top TZ_MAX_LEN bits of the window can hold a codeword.
  if (WIN_W > TZ_MAX_LEN) begin : g_unused
    logic unused_bits;
    assign unused_bits = ^bits_in[WIN_W-TZ_MAX_LEN-1:0];
  end

  tz_lut u_tz_lut (
    .mode        (mode_q),
    .total_coeff (tc_q),
    .win         (bits_in[WIN_W-1 -: TZ_MAX_LEN]),
    .total_zeros (lut_tz),
    .tz_len      (lut_len),
    .match       (lut_match)
  );

  // Classify an incoming request from the live inputs.
  always_comb begin
    req_err  = (total_coeff > max_num_coeff) || (block_mode == MODE_RSVD) ||
               (block_mode == MODE_CDC422 && !EN_422);
    req_skip = (total_coeff == 5'd0) || (total_coeff >= max_num_coeff);
    case (block_mode)
      MODE_LUMA:   req_no_row = total_coeff > 5'd15;
      MODE_CDC420: req_no_row = total_coeff > 5'd3;
      MODE_CDC422: req_no_row = total_coeff > 5'd7;
      default:     req_no_row = 1'b1;
    endcase
  end

  // Next state and next result values.
  always_comb begin
    state_d = state_q;
    tc_d    = tc_q;
    mode_d  = mode_q;
    tz_d    = tz_q;
    len_d   = len_q;
    run_d   = run_q;
    err_d   = err_q;
    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          tc_d   = total_coeff;
          mode_d = block_mode;
          err_d  = 1'b0;
          if (req_err || req_skip || req_no_row) begin
            // Resolved without reading the bitstream.
            state_d = StDone;
            tz_d    = '0;
            len_d   = '0;
            run_d   = 1'b0;
            err_d   = req_err || (!req_skip && req_no_row);
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (bits_valid) begin
          state_d = StDone;
          if (lut_match) begin
            tz_d  = lut_tz;
            len_d = lut_len;
            run_d = (tc_q > 5'd1) && (lut_tz != 4'd0);
          end else begin
            tz_d  = '0;
            len_d = 4'd1;
            run_d = 1'b0;
            err_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, capture and result registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      tc_q    <= '0;
      mode_q  <= '0;
      tz_q    <= '0;
      len_q   <= '0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
      mode_q  <= mode_d;
      tz_q    <= tz_d;
      len_q   <= len_d;
      run_q   <= run_d;
      err_q   <= err_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign consume     = done && (len_q != 4'd0);
  assign total_zeros = tz_q;
  assign tz_len      = len_q;
  assign zeros_left  = tz_q;
  assign run_needed  = run_q;
  assign err         = err_q;

endmodule

// File: tb/tb_total_zeros_decoder_mc.sv
// Bench for total_zeros_decoder_mc: directed cases plus random requests against a string-table model.
module tb_total_zeros_decoder_mc;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [4:0]  total_coeff;
  logic [1:0]  block_mode;
  logic [4:0]  max_num_coeff;
  logic [15:0] bits_in;
  logic        bits_valid;
  logic        busy, done, consume, run_needed, err;
  logic [3:0]  total_zeros, tz_len, zeros_left;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  total_zeros_decoder_mc #(
    .WIN_W  (16),
    .EN_422 (1'b1)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .total_coeff   (total_coeff),
    .block_mode    (block_mode),
    .max_num_coeff (max_num_coeff),
    .bits_in       (bits_in),
    .bits_valid    (bits_valid),
    .busy          (busy),
    .done          (done),
    .total_zeros   (total_zeros),
    .tz_len        (tz_len),
    .consume       (consume),
    .zeros_left    (zeros_left),
    .run_needed    (run_needed),
    .err           (err)
  );

  // Codeword strings indexed [total_coeff-1][total_zeros]; "" = no codeword.
  string luma_tab [15][16] = '{
    '{"1","011","010","0011","0010","00011","00010","000011","000010","0000011","0000010",
      "00000011","00000010","000000011","000000010","000000001"},
    '{"111","110","101","100","011","0101","0100","0011","0010","00011","00010","000011",
      "000010","000001","000000",""},
    '{"0101","111","110","101","0100","0011","100","011","0010","00011","00010","000001",
      "00001","000000","",""},
    '{"00011","111","0101","0100","110","101","100","0011","011","0010","00010","00001",
      "00000","","",""},
    '{"0101","0100","0011","111","110","101","100","011","0010","00001","0001","00000",
      "","","",""},
    '{"000001","00001","111","110","101","100","011","010","0001","001","000000",
      "","","","",""},
    '{"000001","00001","101","100","011","11","010","0001","001","000000",
      "","","","","",""},
    '{"000001","0001","00001","011","11","10","010","001","000000",
      "","","","","","",""},
    '{"000001","000000","0001","11","10","001","01","00001","","","","","","","",""},
    '{"00001","00000","001","11","10","01","0001","","","","","","","","",""},
    '{"0000","0001","001","010","1","011","","","","","","","","","",""},
    '{"0000","0001","01","1","001","","","","","","","","","","",""},
    '{"000","001","1","01","","","","","","","","","","","",""},
    '{"00","01","1","","","","","","","","","","","","",""},
    '{"0","1","","","","","","","","","","","","","",""}
  };
  string c420_tab [3][4] = '{
    '{"1","01","001","000"}, '{"1","01","00",""}, '{"1","0","",""}
  };
  string c422_tab [7][8] = '{
    '{"1","010","011","0010","0011","0001","00001","00000"},
    '{"000","01","001","100","101","110","111",""},
    '{"000","001","01","10","110","111","",""},
    '{"110","00","01","10","111","","",""},
    '{"00","01","10","11","","","",""},
    '{"00","01","1","","","","",""},
    '{"0","1","","","","","",""}
  };

  typedef struct packed {
    logic       err;
    logic       imm;   // resolved without bitstream: done one cycle after start
    logic [3:0] tz;
    logic [3:0] len;
  } exp_t;

  function automatic bit prefix_match(input string c, input logic [15:0] w);
    for (int k = 0; k < c.len(); k++) begin
      if ((c[k] == 8'h31) != w[15-k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic exp_t model(input int mode, input int tc, input int mx,
                                 input logic [15:0] w);
    exp_t  e;
    string c;
    e = '0;
    if (tc > mx || mode == 3) begin
      e.err = 1'b1; e.imm = 1'b1; return e;
    end
    if (tc == 0 || tc >= mx) begin
      e.imm = 1'b1; return e;
    end
    if ((mode == 0 && tc > 15) || (mode == 1 && tc > 3) || (mode == 2 && tc > 7)) begin
      e.err = 1'b1; e.imm = 1'b1; return e;
    end
    for (int v = 0; v < 16; v++) begin
      c = "";
      if (mode == 0) c = luma_tab[tc-1][v];
      else if (mode == 1 && v < 4) c = c420_tab[tc-1][v];
      else if (mode == 2 && v < 8) c = c422_tab[tc-1][v];
      if (c.len() > 0 && prefix_match(c, w)) begin
        e.tz = 4'(v); e.len = 4'(c.len()); return e;
      end
    end
    e.err = 1'b1; e.len = 4'd1;
    return e;
  endfunction

  task automatic check(input string tag, input string name, input logic [15:0] obs,
                       input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed %0h expected %0h", tag, name, obs, exp);
    end
  endtask

  // Issue one request at the current negedge; checks latency and the registered results.
  task automatic request(input string tag, input int mode, input int tc, input int mx,
                         input logic [15:0] w, input int delay, input bit b2b);
    exp_t e;
    e = model(mode, tc, mx, w);
    start = 1'b1; block_mode = 2'(mode); total_coeff = 5'(tc); max_num_coeff = 5'(mx);
    bits_in = w; bits_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    if (!e.imm) begin
      check(tag, "early_done", {15'd0, done}, 16'd0);
      check(tag, "wait_busy", {15'd0, busy}, 16'd1);
      for (int i = 0; i < delay; i++) begin
        if (i == 0) begin
          // A start while waiting must be ignored.
          start = 1'b1; total_coeff = 5'(tc ^ 1); block_mode = 2'(mode ^ 1);
        end
        @(negedge clk);
        start = 1'b0; total_coeff = 5'(tc); block_mode = 2'(mode);
        check(tag, "stall_done", {15'd0, done}, 16'd0);
        check(tag, "stall_busy", {15'd0, busy}, 16'd1);
      end
      bits_valid = 1'b1;
      @(negedge clk);
      bits_valid = 1'b0;
    end
    check(tag, "done", {15'd0, done}, 16'd1);
    check(tag, "busy", {15'd0, busy}, 16'd1);
    check(tag, "total_zeros", {12'd0, total_zeros}, {12'd0, e.tz});
    check(tag, "tz_len", {12'd0, tz_len}, {12'd0, e.len});
    check(tag, "zeros_left", {12'd0, zeros_left}, {12'd0, e.tz});
    check(tag, "consume", {15'd0, consume}, {15'd0, e.len != 4'd0});
    check(tag, "run_needed", {15'd0, run_needed}, {15'd0, tc > 1 && e.tz != 4'd0});
    check(tag, "err", {15'd0, err}, {15'd0, e.err});
    if (!b2b) begin
      @(negedge clk);
      check(tag, "done_pulse", {15'd0, done}, 16'd0);
      check(tag, "idle_busy", {15'd0, busy}, 16'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, "busy", {15'd0, busy}, 16'd0);
    check(tag, "done", {15'd0, done}, 16'd0);
    check(tag, "consume", {15'd0, consume}, 16'd0);
    check(tag, "total_zeros", {12'd0, total_zeros}, 16'd0);
    check(tag, "tz_len", {12'd0, tz_len}, 16'd0);
    check(tag, "zeros_left", {12'd0, zeros_left}, 16'd0);
    check(tag, "run_needed", {15'd0, run_needed}, 16'd0);
    check(tag, "err", {15'd0, err}, 16'd0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; total_coeff = '0; block_mode = '0;
    max_num_coeff = '0; bits_in = '0; bits_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    request("luma_011", 0, 1, 16, 16'h6000, 0, 1'b0);
    request("luma_tz15", 0, 1, 16, 16'h0080, 0, 1'b0);
    request("luma_tc15", 0, 15, 16, 16'h8000, 0, 1'b0);
    request("c422_0011", 2, 1, 8, 16'h3000, 0, 1'b0);
    request("c420_00", 1, 2, 4, 16'h0000, 0, 1'b0);
    request("skip_tc16", 0, 16, 16, 16'hFFFF, 0, 1'b0);
    request("skip_tc0", 0, 0, 16, 16'h1234, 0, 1'b0);
    request("wait5", 0, 2, 16, 16'hE000, 5, 1'b1);
    request("b2b", 0, 3, 16, 16'h4000, 0, 1'b0);
    request("mode3", 3, 1, 16, 16'h8000, 0, 1'b0);
    request("c420_tc5", 1, 5, 4, 16'h8000, 0, 1'b0);
    request("unmatched", 0, 1, 16, 16'h0000, 0, 1'b0);
    request("after_err", 1, 1, 4, 16'h2000, 0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      int          m, tc, mx, d;
      logic [15:0] w;
      m = ($urandom_range(0, 19) == 0) ? 3 : int'($urandom_range(0, 2));
      case (m)
        0:       mx = ($urandom_range(0, 1) == 1) ? 16 : 15;
        1:       mx = 4;
        2:       mx = 8;
        default: mx = 16;
      endcase
      if ($urandom_range(0, 9) == 0) mx = int'($urandom_range(0, 16));
      tc = int'($urandom_range(0, (mx < 16) ? mx + 1 : 16));
      w  = 16'($urandom) >> $urandom_range(0, 9);
      d  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      request("rnd", m, tc, mx, w, d, 1'($urandom_range(0, 1)));
    end
    @(negedge clk);
    @(negedge clk);

    // Reset while waiting for bits abandons the block.
    start = 1'b1; block_mode = 2'd0; total_coeff = 5'd3; max_num_coeff = 5'd16;
    bits_in = 16'h4000; bits_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    check_all_zero("rst_wait");
    reset_n = 1'b1;
    bits_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_wait", "no_done", {15'd0, done}, 16'd0);
      check("rst_wait", "no_consume", {15'd0, consume}, 16'd0);
    end
    bits_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/total_zeros_decoder_mc.md
Name: total_zeros_decoder_mc

Overview:
- Multi-mode CAVLC total_zeros decoder with a start/done handshake. It replaces the single-table combinational lookup.
- Supports three code-table sets:
  - 4x4 luma/AC: Tables 9-7/9-8.
  - Chroma DC 4:2:0: Table 9-9a.
  - Chroma DC 4:2:2: Table 9-9b.
- Does its own leading-one detection on an MSB-first bitstream window.
- Registers its results and exposes zeros_left/run_needed for the run_before stage. Sits between the level decoder and run_before decoder in the CAVLC pipeline.

Parameters:
- WIN_W, 16, width of the bitstream window; must be >= 9.
- EN_422, 1, 1 = 4:2:2 chroma DC table present; 0 = mode 2 is flagged as an error.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset
- start  in  1  one-cycle request; samples total_coeff, block_mode, max_num_coeff
- total_coeff  in  5  TotalCoeff of the current block, 0..16
- block_mode  in  2  0 = luma/AC, 1 = chroma DC 4:2:0, 2 = chroma DC 4:2:2, 3 = reserved
- max_num_coeff  in  5  maxNumCoeff: 16/15 luma, 4 for 4:2:0, 8 for 4:2:2
- bits_in  in  WIN_W  bitstream window; bits_in[WIN_W-1] is the next unread bit
- bits_valid  in  1  bits_in holds a valid aligned window
- busy  out  1  high in WAIT and DONE states
- done  out  1  one-cycle pulse; result outputs are valid
- total_zeros  out  4  decoded total_zeros, held until the next done
- tz_len  out  4  codeword length in bits (0 when skipped), held
- consume  out  1  pulse coincident with done; the bitstream shifter advances tz_len
- zeros_left  out  4  equals total_zeros; initial zerosLeft for run_before
- run_needed  out  1  (total_coeff > 1) && (total_zeros != 0)
- err  out  1  sticky until the next start: illegal total_coeff/mode or no matching codeword

Behaviour:
- Reset: reset_n is synchronous and active-low on clk. All outputs go to 0 and the state goes to IDLE. Reset mid-operation abandons the block with no done and no consume.
- States:
  - IDLE:
    - start=0 -> stay in IDLE.
    - start=1 with skip condition -> go to DONE.
    - start=1 otherwise -> go to WAIT.
  - Skip condition: total_coeff == 0, or total_coeff >= max_num_coeff.
  - Skip result: total_zeros=0, tz_len=0, no bits consumed.
  - Error cases: total_coeff > max_num_coeff, block_mode == 3, or block_mode == 2 with EN_422=0. These set err, force total_zeros=0, and go to DONE.
  - WAIT: hold the captured inputs. When bits_valid=1, evaluate the LUT and register total_zeros, tz_len and zeros_left, then go to DONE. While bits_valid=0, stay in WAIT indefinitely with no timeout.
  - DONE: assert done and consume (consume is forced to 0 when tz_len == 0), then go to IDLE.
  - start in DONE: accepted as a new request (back-to-back). start in WAIT: ignored.
- Latency:
  - Normal decode: start in cycle N, with bits_valid high in N+1, gives done in N+2.
  - Skip: done in N+1.
- Leading-one position p: the count of leading zeros in bits_in[WIN_W-1 -: 9]. If all 9 bits are 0, p=9. Codewords only look at bits up to p+2 below the MSB.
- Table selection:
  - Mode 0: row total_coeff 1..15.
  - Mode 1: row 1..3.
  - Mode 2: row 1..7.
- Unmatched code: p=9 in mode 0 row 1, or any pattern absent from the table. Sets err, total_zeros=0, tz_len=1.
- 4:2:0 table, codeword -> value:
  - Row 1: 1->0, 01->1, 001->2, 000->3.
  - Row 2: 1->0, 01->1, 00->2.
  - Row 3: 1->0, 0->1.
- 4:2:2 table, codeword -> value:
  - Row 1: 1->0, 010->1, 011->2, 0010->3, 0011->4, 0001->5, 00001->6, 00000->7.
  - Row 2: 000->0, 01->1, 001->2, 100->3, 101->4, 110->5, 111->6.
  - Row 3: 000->0, 001->1, 01->2, 10->3, 110->4, 111->5.
  - Row 4: 110->0, 00->1, 01->2, 10->3, 111->4.
  - Row 5: 00->0, 01->1, 10->2, 11->3.
  - Row 6: 00->0, 01->1, 1->2.
  - Row 7: 0->0, 1->1.
- Width rules: all values fit in 4 bits; tz_len maximum is 9. No arithmetic overflow is possible.

Decomposition:
- Shared package h264_cavlc_pkg:
  - block_mode encodings (MODE_LUMA, MODE_CDC420, MODE_CDC422).
  - State encoding.
  - Constant TZ_MAX_LEN=9.
- One combinational sub-module, tz_lut:
  - Inputs: mode, total_coeff, 9-bit window.
  - Outputs: total_zeros, tz_len, match.
  - Contains the leading-one detector and all three table sets.
- The FSM, capture registers, output registers and error flag stay in total_zeros_decoder_mc.

Test Plan:
- Mode 0, total_coeff=1, bits_in=0x6000 ("011") -> done at start+2, total_zeros=1, tz_len=3, consume=1, run_needed=0.
- Mode 0, total_coeff=1, bits_in=0x0080 ("000000001") -> total_zeros=15, tz_len=9. Then total_coeff=15, bits_in=0x8000 -> total_zeros=1, tz_len=1, run_needed=1.
- Mode 2, total_coeff=1, bits_in=0x3000 ("0011") -> total_zeros=4, tz_len=4. Mode 1, total_coeff=2, bits_in=0x0000 -> total_zeros=2, tz_len=2.
- total_coeff=16 in mode 0 with max 16, and total_coeff=0 -> done at start+1, tz_len=0, consume=0, err=0.
- bits_valid held low 5 cycles after start -> busy=1, no done. Raise bits_valid -> done next cycle. Then issue start in the DONE cycle -> second result is correct.
- Mode 3, or total_coeff=5 in mode 1 -> err=1, total_zeros=0. reset_n low during WAIT -> outputs 0, no done pulse.
